// File: rtl/adma_pkg.sv
// Shared constants for the ADMA data mover: one-hot FSM states and byte-lane helpers.
package adma_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BYTES      = DATA_W_DEF / 8;
  localparam int BE_W       = BYTES;

  typedef enum logic [6:0] {
    S_IDLE       = 7'b000_0001,
    S_FIFO_RAM   = 7'b000_0010,
    S_RAM_FIFO   = 7'b000_0100,
    S_WAIT_READ  = 7'b000_1000,
    S_WAIT_WRITE = 7'b001_0000,
    S_DONE       = 7'b010_0000,
    S_ERROR      = 7'b100_0000
  } state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/adma_xfer_engine_if.sv
// Signal bundle between the transfer engine, the system-RAM port, the SD data FIFO and the descriptor FSM.
// master = engine side; slave = everything around it.
interface adma_xfer_engine_if
  import adma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
);

  logic                  start;
  logic                  direction;
  logic                  abort;
  logic [ADDR_W-1:0]     address_init;
  logic [LEN_W-1:0]      length;
  logic                  ram_read;
  logic                  ram_write;
  logic [ADDR_W-1:0]     ram_address;
  logic [DATA_W/8-1:0]   ram_be;
  logic [DATA_W-1:0]     data_from_ram;
  logic [DATA_W-1:0]     data_to_ram;
  logic                  fifo_read;
  logic                  fifo_write;
  logic [DATA_W-1:0]     data_from_fifo;
  logic [DATA_W-1:0]     data_to_fifo;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  busy;
  logic                  TFC;
  logic                  err;

  modport master (
    input  start, direction, abort, address_init, length,
    input  data_from_ram, data_from_fifo, fifo_empty, fifo_full,
    output ram_read, ram_write, ram_address, ram_be, data_to_ram,
    output fifo_read, fifo_write, data_to_fifo, busy, TFC, err
  );

  modport slave (
    output start, direction, abort, address_init, length,
    output data_from_ram, data_from_fifo, fifo_empty, fifo_full,
    input  ram_read, ram_write, ram_address, ram_be, data_to_ram,
    input  fifo_read, fifo_write, data_to_fifo, busy, TFC, err
  );

endinterface

// File: rtl/adma_len_calc.sv
// Converts a descriptor byte length (0 = 2^LEN_W) into a word count and the final word's byte enables.
// Purely combinational; no handshake.
module adma_len_calc
  import adma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = 16
) (
  input  logic [LEN_W-1:0]    length,
  output logic [LEN_W:0]      words,
  output logic [DATA_W/8-1:0] last_be
);

  localparam int NB = bytes_of(DATA_W);
  localparam int SH = $clog2(NB);

  logic [LEN_W:0] len_bytes;

  // The extra top bit turns a zero length into the full 2^LEN_W byte count.
  assign len_bytes = {(length == '0), length};

  generate
    if (SH == 0) begin : g_byte_lanes
      assign words   = len_bytes;
      assign last_be = '1;
    end else begin : g_multi_lanes
      logic [SH-1:0] rem;
      assign rem   = len_bytes[SH-1:0];
      assign words = (len_bytes >> SH) + {{LEN_W{1'b0}}, (rem != '0)};

      always_comb begin
        last_be = '0;
        for (int i = 0; i < NB; i++) begin
          last_be[i] = (rem == '0) || (i < int'(rem));
        end
      end
    end
  endgenerate

endmodule

// File: rtl/adma_xfer_engine.sv
// Moves one descriptor's worth of words between system RAM and the SD data FIFO, one word per cycle.
// Stalls in a wait state on FIFO empty/full; times out to err, abort drops strobes in the same cycle.
module adma_xfer_engine
  import adma_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = 64,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                CLK,
  input logic                RESET,
  adma_xfer_engine_if.master bus
);

  localparam int NB   = bytes_of(DATA_W);
  localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LEN_W:0]  WL_ONE     = (LEN_W+1)'(1);
  localparam logic [ST_W-1:0] ST_ONE     = ST_W'(1);
  localparam logic [ST_W-1:0] STALL_LAST = ST_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W:0]      words_left;
  logic [NB-1:0]       last_be;
  logic [ST_W-1:0]     stall_cnt;
  logic [LEN_W:0]      len_words;
  logic [NB-1:0]       len_last_be;
  logic                xfer;
  logic                last_word;

  adma_len_calc #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_len_calc (
    .length  (bus.length),
    .words   (len_words),
    .last_be (len_last_be)
  );

  assign last_word       = (words_left == WL_ONE);
  assign bus.ram_address = addr;

  always_comb begin
    state_nxt          = state;
    xfer               = 1'b0;
    bus.ram_read       = 1'b0;
    bus.ram_write      = 1'b0;
    bus.fifo_read      = 1'b0;
    bus.fifo_write     = 1'b0;
    bus.ram_be         = '0;
    bus.data_to_ram    = '0;
    bus.data_to_fifo   = '0;
    bus.busy           = (state != S_IDLE);
    bus.TFC            = 1'b0;
    bus.err            = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = bus.direction ? S_RAM_FIFO : S_FIFO_RAM;
        end
      end
      S_FIFO_RAM: begin
        if (bus.fifo_empty) begin
          state_nxt = S_WAIT_READ;
        end else begin
          xfer            = 1'b1;
          bus.fifo_read   = 1'b1;
          bus.ram_write   = 1'b1;
          bus.data_to_ram = bus.data_from_fifo;
          bus.ram_be      = last_word ? last_be : '1;
          if (last_word) state_nxt = S_DONE;
        end
      end
      S_RAM_FIFO: begin
        if (bus.fifo_full) begin
          state_nxt = S_WAIT_WRITE;
        end else begin
          xfer             = 1'b1;
          bus.ram_read     = 1'b1;
          bus.fifo_write   = 1'b1;
          bus.data_to_fifo = bus.data_from_ram;
          if (last_word) state_nxt = S_DONE;
        end
      end
      S_WAIT_READ: begin
        if (!bus.fifo_empty)              state_nxt = S_FIFO_RAM;
        else if (stall_cnt == STALL_LAST) state_nxt = S_ERROR;
      end
      S_WAIT_WRITE: begin
        if (!bus.fifo_full)               state_nxt = S_RAM_FIFO;
        else if (stall_cnt == STALL_LAST) state_nxt = S_ERROR;
      end
      S_DONE: begin
        bus.TFC   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        bus.err   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort beats everything, including the final word and the DONE/ERROR pulse.
    if (bus.abort && (state != S_IDLE)) begin
      state_nxt        = S_IDLE;
      xfer             = 1'b0;
      bus.ram_read     = 1'b0;
      bus.ram_write    = 1'b0;
      bus.fifo_read    = 1'b0;
      bus.fifo_write   = 1'b0;
      bus.ram_be       = '0;
      bus.data_to_ram  = '0;
      bus.data_to_fifo = '0;
      bus.TFC          = 1'b0;
      bus.err          = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      addr       <= '0;
      words_left <= '0;
      last_be    <= '0;
      stall_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && bus.start) begin
        addr       <= bus.address_init & ~ADDR_W'(NB - 1);
        words_left <= len_words;
        last_be    <= len_last_be;
      end else if (xfer) begin
        addr       <= addr + ADDR_W'(NB);
        words_left <= words_left - WL_ONE;
      end
      // Any non-wait cycle clears the count, so each stall episode starts from zero.
      stall_cnt <= ((state == S_WAIT_READ) || (state == S_WAIT_WRITE)) ? stall_cnt + ST_ONE : '0;
    end
  end

endmodule

// File: tb/tb_adma_xfer_engine.sv
// Directed bench for adma_xfer_engine: a vector table on a 16-bit-length instance plus
// hand sequences for abort, mid-transfer reset, zero length and stall timeout.
module tb_adma_xfer_engine;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adma_xfer_engine_if #(.DATA_W(32), .ADDR_W(64), .LEN_W(16)) ia ();
  adma_xfer_engine_if #(.DATA_W(32), .ADDR_W(64), .LEN_W(4))  ib ();

  adma_xfer_engine #(.DATA_W(32), .ADDR_W(64), .LEN_W(16), .TIMEOUT_CYCLES(1024)) dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ia)
  );

  adma_xfer_engine #(.DATA_W(32), .ADDR_W(64), .LEN_W(4), .TIMEOUT_CYCLES(8)) dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ib)
  );

  typedef struct {
    logic        dir;
    logic [63:0] addr;
    logic [15:0] len;
    int          st_lo;
    int          st_hi;
    int          words;
    logic [3:0]  last_be;
    int          busy;
    int          last_cyc;
    logic [63:0] addr0;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   nw, busy_n, tfc_n, tfc_c, err_n, last_c, st_strb;
    bit   done, stalled;
    logic [3:0] exp_be;
    nw = 0; busy_n = 0; tfc_n = 0; tfc_c = -1; err_n = 0; last_c = -1; st_strb = 0; done = 0;
    @(negedge clk);
    ia.start = 1'b1; ia.direction = v.dir; ia.address_init = v.addr; ia.length = v.len;
    ia.fifo_empty = 1'b0; ia.fifo_full = 1'b0;
    @(negedge clk);
    ia.start = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      stalled = (cyc >= v.st_lo) && (cyc < v.st_hi);
      ia.fifo_empty     = !v.dir && stalled;
      ia.fifo_full      = v.dir && stalled;
      ia.data_from_fifo = 32'hA500_0000 + cyc;
      ia.data_from_ram  = 32'h5A00_0000 + cyc;
      #1;
      if (!ia.busy) begin
        done = 1;
      end else begin
        busy_n++;
        if (ia.TFC) begin tfc_n++; tfc_c = cyc; end
        if (ia.err) err_n++;
        if (ia.ram_write || ia.ram_read) begin
          if (stalled) st_strb++;
          exp_be = v.dir ? 4'h0 : ((nw == v.words - 1) ? v.last_be : 4'hF);
          chk($sformatf("v%0d_addr%0d", idx, nw), ia.ram_address, v.addr0 + 64'(4 * nw));
          chk($sformatf("v%0d_be%0d", idx, nw), ia.ram_be, exp_be);
          chk($sformatf("v%0d_strb%0d", idx, nw),
              {ia.ram_read, ia.ram_write, ia.fifo_read, ia.fifo_write}, v.dir ? 4'b1001 : 4'b0110);
          chk($sformatf("v%0d_data%0d", idx, nw), v.dir ? ia.data_to_fifo : ia.data_to_ram,
              v.dir ? 32'h5A00_0000 + cyc : 32'hA500_0000 + cyc);
          nw++;
          last_c = cyc;
        end
        @(negedge clk);
      end
    end
    ia.fifo_empty = 1'b0; ia.fifo_full = 1'b0;
    chk($sformatf("v%0d_finished", idx), done, 1);
    chk($sformatf("v%0d_words", idx), nw, v.words);
    chk($sformatf("v%0d_busy_cycles", idx), busy_n, v.busy);
    chk($sformatf("v%0d_last_cycle", idx), last_c, v.last_cyc);
    chk($sformatf("v%0d_tfc_count", idx), tfc_n, 1);
    chk($sformatf("v%0d_tfc_cycle", idx), tfc_c, v.last_cyc + 1);
    chk($sformatf("v%0d_err_count", idx), err_n, 0);
    chk($sformatf("v%0d_stall_strobes", idx), st_strb, 0);
  endtask

  task automatic run_abort();
    int nw, pulses;
    nw = 0; pulses = 0;
    @(negedge clk);
    ia.start = 1'b1; ia.direction = 1'b0; ia.address_init = 64'h3000; ia.length = 16'd16;
    @(negedge clk);
    ia.start = 1'b0;
    #1;
    if (ia.ram_write) nw++;
    @(negedge clk);
    ia.abort = 1'b1;
    #1;
    if (ia.ram_write) nw++;
    pulses += int'(ia.TFC) + int'(ia.err);
    chk("abort_strobes", {ia.ram_read, ia.ram_write, ia.fifo_read, ia.fifo_write, ia.ram_be}, 8'h00);
    @(negedge clk);
    ia.abort = 1'b0;
    #1;
    pulses += int'(ia.TFC) + int'(ia.err);
    chk("abort_idle", ia.busy, 0);
    chk("abort_words_moved", nw, 1);
    chk("abort_no_tfc_err", pulses, 0);
    ia.start = 1'b1; ia.direction = 1'b1; ia.address_init = 64'h5000; ia.length = 16'd4;
    @(negedge clk);
    ia.start = 1'b0;
    #1;
    chk("restart_busy", ia.busy, 1);
    chk("restart_read", {ia.ram_read, ia.fifo_write}, 2'b11);
    chk("restart_addr", ia.ram_address, 64'h5000);
    @(negedge clk);
    #1;
    chk("restart_tfc", ia.TFC, 1);
    @(negedge clk);
    #1;
    chk("restart_idle", ia.busy, 0);
  endtask

  task automatic run_reset_mid();
    @(negedge clk);
    ia.start = 1'b1; ia.direction = 1'b0; ia.address_init = 64'h6000; ia.length = 16'd16;
    @(negedge clk);
    ia.start = 1'b0;
    #1;
    chk("rstmid_first_write", ia.ram_write, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_outputs", {ia.busy, ia.ram_write, ia.fifo_read, ia.TFC, ia.err}, 5'b0);
    chk("rstmid_addr", ia.ram_address, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_after_release", {ia.busy, ia.TFC, ia.err}, 3'b0);
    @(negedge clk);
    #1;
    chk("rstmid_stays_idle", {ia.busy, ia.ram_write, ia.TFC, ia.err}, 4'b0);
  endtask

  task automatic run_b_len0();
    int nw, tfc_n;
    bit done;
    logic [3:0]  be_last;
    logic [63:0] a_last;
    nw = 0; tfc_n = 0; done = 0; be_last = 4'h0; a_last = 64'h0;
    @(negedge clk);
    ib.start = 1'b1; ib.direction = 1'b0; ib.address_init = 64'h100; ib.length = 4'd0;
    ib.fifo_empty = 1'b0; ib.fifo_full = 1'b0;
    @(negedge clk);
    ib.start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!ib.busy) begin
        done = 1;
      end else begin
        if (ib.ram_write) begin nw++; be_last = ib.ram_be; a_last = ib.ram_address; end
        if (ib.TFC) tfc_n++;
        @(negedge clk);
      end
    end
    chk("len0_finished", done, 1);
    chk("len0_words", nw, 4);
    chk("len0_last_be", be_last, 4'hF);
    chk("len0_last_addr", a_last, 64'h10C);
    chk("len0_tfc", tfc_n, 1);
  endtask

  task automatic run_b_timeout();
    int err_n, err_c, idle_c, strb, tfc_n;
    err_n = 0; err_c = -1; idle_c = -1; strb = 0; tfc_n = 0;
    @(negedge clk);
    ib.start = 1'b1; ib.direction = 1'b0; ib.address_init = 64'h200; ib.length = 4'd8;
    ib.fifo_empty = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    for (int c = 0; c < 40 && idle_c < 0; c++) begin
      // A start while busy must be ignored.
      ib.start     = (c == 3);
      ib.direction = 1'b1;
      #1;
      if (!ib.busy) begin
        idle_c = c;
      end else begin
        if (ib.err) begin err_n++; err_c = c; end
        if (ib.TFC) tfc_n++;
        if (ib.ram_write || ib.ram_read || ib.fifo_read || ib.fifo_write) strb++;
        @(negedge clk);
      end
    end
    ib.start = 1'b0; ib.fifo_empty = 1'b0;
    chk("tmo_err_count", err_n, 1);
    chk("tmo_err_cycle", err_c, 9);
    chk("tmo_idle_cycle", idle_c, 10);
    chk("tmo_no_strobes", strb, 0);
    chk("tmo_no_tfc", tfc_n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ia.start = 1'b0; ia.direction = 1'b0; ia.abort = 1'b0; ia.address_init = '0; ia.length = '0;
    ia.data_from_ram = '0; ia.data_from_fifo = '0; ia.fifo_empty = 1'b0; ia.fifo_full = 1'b0;
    ib.start = 1'b0; ib.direction = 1'b0; ib.abort = 1'b0; ib.address_init = '0; ib.length = '0;
    ib.data_from_ram = '0; ib.data_from_fifo = '0; ib.fifo_empty = 1'b0; ib.fifo_full = 1'b0;

    //              dir   addr                    len    lo hi wrd be     busy last addr0
    vecs[0] = '{1'b0, 64'h1000,               16'd16, 0, 0, 4, 4'hF, 5, 3, 64'h1000};
    vecs[1] = '{1'b1, 64'h1000,               16'd10, 0, 0, 3, 4'h0, 4, 2, 64'h1000};
    vecs[2] = '{1'b0, 64'h2000,               16'd6,  0, 0, 2, 4'h3, 3, 1, 64'h2000};
    vecs[3] = '{1'b1, 64'h1000,               16'd16, 2, 5, 4, 4'h0, 9, 7, 64'h1000};
    vecs[4] = '{1'b0, 64'h1003,               16'd5,  0, 0, 2, 4'h1, 3, 1, 64'h1000};
    vecs[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 16'd8,  0, 0, 2, 4'hF, 3, 1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[6] = '{1'b0, 64'h4000,               16'd8,  1, 2, 2, 4'hF, 5, 3, 64'h4000};
    vecs[7] = '{1'b1, 64'h7000,               16'd1,  0, 0, 1, 4'h0, 2, 0, 64'h7000};

    #12;
    chk("reset_ctrl", {ia.busy, ia.TFC, ia.err, ib.busy, ib.TFC, ib.err}, 6'b0);
    chk("reset_strobes", {ia.ram_read, ia.ram_write, ia.fifo_read, ia.fifo_write}, 4'b0);
    chk("reset_addr", ia.ram_address, 64'h0);
    chk("reset_be", ia.ram_be, 4'h0);
    chk("reset_data", {ia.data_to_ram, ia.data_to_fifo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    run_abort();
    run_reset_mid();
    run_b_len0();
    run_b_timeout();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
